// File: rtl/iob_uart_rs232_rx_if.sv
// Receive-side byte handshake between the RS-232 receiver and its consumer.
// The master modport is the receiver (produces bytes and status pulses),
// the slave modport is the consumer (accepts bytes with data_ready_i).
interface iob_uart_rs232_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_o;
  logic              data_valid_o;
  logic              data_ready_i;
  logic              frame_err_o;
  logic              overrun_o;
  logic              parity_err_o;

  modport master (
    output data_o,
    output data_valid_o,
    output frame_err_o,
    output overrun_o,
    output parity_err_o,
    input  data_ready_i
  );

  modport slave (
    input  data_o,
    input  data_valid_o,
    input  frame_err_o,
    input  overrun_o,
    input  parity_err_o,
    output data_ready_i
  );
endinterface

// File: rtl/iob_uart_rs232_rx.sv
// Standalone RS-232 receive endpoint: deserializes 8N1 frames (LSB first)
// into a one-byte holding register with a valid/ready handshake and drives
// RTS from holding-register occupancy.
// Optional feature macro IOB_UART_RX_PARITY_EN: adds an even-parity bit
// after the data bits (8E1) and reports mismatches on parity_err_o.
module iob_uart_rs232_rx #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                en_i,
  input  logic [DIV_W-1:0]    div_i,
  input  logic                rs232_rxd_i,
  output logic                rs232_rts_o,
  iob_uart_rs232_rx_if.master rx_if
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t             state_q, state_d;
  logic               rxd_meta_q, rxs_q, rxs_prev_q;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               rts_q, rts_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
`ifdef IOB_UART_RX_PARITY_EN
  logic               par_q, par_d;
  logic               parity_err_q, parity_err_d;
`endif

  logic [DIV_W-1:0]   div_eff;
  logic               start_edge;
  logic               tick;
  logic               stop_hit;
  logic               consume;
  logic               deliver;

  // Divisors below 2 would leave no room for a mid-bit sample, so clamp to 2.
  assign div_eff    = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;
  assign start_edge = en_i & (state_q == ST_IDLE) & rxs_prev_q & ~rxs_q;
  assign tick       = (cnt_q == '0);
  assign stop_hit   = en_i & (state_q == ST_STOP) & tick;
  assign consume    = valid_q & rx_if.data_ready_i;
`ifdef IOB_UART_RX_PARITY_EN
  assign deliver    = stop_hit & rxs_q & ~par_q;
`else
  assign deliver    = stop_hit & rxs_q;
`endif

  // State register plus all datapath flops; cke_i low freezes everything.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q      <= ST_IDLE;
      rxd_meta_q   <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      cnt_q        <= '0;
      div_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      rts_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef IOB_UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else if (cke_i) begin
      state_q      <= state_d;
      rxd_meta_q   <= rs232_rxd_i;
      rxs_q        <= rxd_meta_q;
      rxs_prev_q   <= rxs_q;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      rts_q        <= rts_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef IOB_UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Frame sequencing; disabling the receiver abandons any partial frame.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start_edge) state_d = ST_START;
        ST_START:  if (tick) state_d = rxs_q ? ST_IDLE : ST_DATA;
        ST_DATA: begin
          if (tick && (bit_idx_q == LAST_IDX)) begin
`ifdef IOB_UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
        ST_PARITY: if (tick) state_d = ST_STOP;
        ST_STOP:   if (tick) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Bit timing, shifting, holding-register handshake and status pulses.
  always_comb begin
    cnt_d        = cnt_q;
    div_d        = div_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    rts_d        = en_i & ~valid_q;
`ifdef IOB_UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    if (start_edge) begin
      div_d = div_eff;
      cnt_d = (div_eff >> 1) - DIV_W'(1);
    end else if (en_i && (state_q != ST_IDLE)) begin
      cnt_d = tick ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
    end

    if (en_i && tick) begin
      case (state_q)
        ST_START: begin
          bit_idx_d = '0;
`ifdef IOB_UART_RX_PARITY_EN
          par_d     = 1'b0;
`endif
        end
        ST_DATA: begin
          shift_d   = {rxs_q, shift_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
`ifdef IOB_UART_RX_PARITY_EN
          par_d     = par_q ^ rxs_q;
`endif
        end
`ifdef IOB_UART_RX_PARITY_EN
        ST_PARITY: par_d = par_q ^ rxs_q;
`endif
        default: ;
      endcase
    end

    if (stop_hit && !rxs_q) begin
      frame_err_d = 1'b1;
    end
`ifdef IOB_UART_RX_PARITY_EN
    else if (stop_hit && par_q) begin
      parity_err_d = 1'b1;
    end
`endif

    if (deliver && (!valid_q || consume)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else begin
      if (deliver) overrun_d = 1'b1;
      if (consume) valid_d = 1'b0;
    end
  end

  assign rs232_rts_o        = rts_q;
  assign rx_if.data_o       = data_q;
  assign rx_if.data_valid_o = valid_q;
  assign rx_if.frame_err_o  = frame_err_q;
  assign rx_if.overrun_o    = overrun_q;
`ifdef IOB_UART_RX_PARITY_EN
  assign rx_if.parity_err_o = parity_err_q;
`else
  assign rx_if.parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_uart_rs232_rx.sv
// Directed self-checking bench for iob_uart_rs232_rx. Builds with or without
// IOB_UART_RX_PARITY_EN; frame timing and parity bits follow the build.
module tb_iob_uart_rs232_rx;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;
`ifdef IOB_UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
  logic par_flip = 1'b0;
`else
  localparam int PAR_BITS = 0;
`endif

  logic             clk_i       = 1'b0;
  logic             arst_n_i    = 1'b0;
  logic             cke_i       = 1'b1;
  logic             en_i        = 1'b1;
  logic [DIV_W-1:0] div_i       = 16'd16;
  logic             rs232_rxd_i = 1'b1;
  logic             rs232_rts_o;

  int checks   = 0;
  int errors   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int perr_cnt = 0;
  int base_f, base_o, base_p;

  iob_uart_rs232_rx_if #(.DATA_W(DATA_W)) rx_if ();

  iob_uart_rs232_rx #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .cke_i       (cke_i),
    .en_i        (en_i),
    .div_i       (div_i),
    .rs232_rxd_i (rs232_rxd_i),
    .rs232_rts_o (rs232_rts_o),
    .rx_if       (rx_if)
  );

  always #5 clk_i = ~clk_i;

  // Count status pulses, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (rx_if.frame_err_o)  ferr_cnt++;
    if (rx_if.overrun_o)    ovr_cnt++;
    if (rx_if.parity_err_o) perr_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Cycles from the first driven start-bit level to the cycle in which the
  // delivered byte (or a status pulse) is visible: 2 sync stages, half a bit,
  // data (+parity) + stop bit periods, then one register stage.
  function automatic int latency(input int d);
    return 3 + d / 2 + (DATA_W + 1 + PAR_BITS) * d;
  endfunction

  // Serialize one frame at d clocks per bit, then leave the line idle briefly.
  task automatic applyStimulus(input logic [7:0] value, input logic stop_bit, input int d);
    rs232_rxd_i = 1'b0;
    waitEdges(d);
    for (int k = 0; k < DATA_W; k++) begin
      rs232_rxd_i = value[k];
      waitEdges(d);
    end
`ifdef IOB_UART_RX_PARITY_EN
    rs232_rxd_i = (^value) ^ par_flip;
    waitEdges(d);
`endif
    rs232_rxd_i = stop_bit;
    waitEdges(d);
    rs232_rxd_i = 1'b1;
    waitEdges(4);
  endtask

  task automatic consumeByte();
    rx_if.data_ready_i = 1'b1;
    waitEdges(1);
    rx_if.data_ready_i = 1'b0;
  endtask

  initial begin
    rx_if.data_ready_i = 1'b0;

    // Reset state
    @(posedge clk_i);
    #1;
    checkOutput("reset_rts", rs232_rts_o, 0);
    checkOutput("reset_data", rx_if.data_o, 0);
    checkOutput("reset_valid", rx_if.data_valid_o, 0);
    checkOutput("reset_pulses", {rx_if.frame_err_o, rx_if.overrun_o, rx_if.parity_err_o}, 0);
    waitEdges(2);
    arst_n_i = 1'b1;
    waitEdges(2);
    checkOutput("rts_after_reset", rs232_rts_o, 1);

    // Basic frame 0xA5 at div 16 with exact delivery latency
    fork
      applyStimulus(8'hA5, 1'b1, 16);
      begin
        waitEdges(latency(16) - 1);
        checkOutput("a5_valid_early", rx_if.data_valid_o, 0);
        waitEdges(1);
        checkOutput("a5_valid", rx_if.data_valid_o, 1);
        checkOutput("a5_data", rx_if.data_o, 8'hA5);
        checkOutput("a5_rts_still_high", rs232_rts_o, 1);
        waitEdges(1);
        checkOutput("a5_rts_low", rs232_rts_o, 0);
      end
    join

    // Clock enable low blocks the handshake
    cke_i = 1'b0;
    rx_if.data_ready_i = 1'b1;
    waitEdges(3);
    checkOutput("cke_hold_valid", rx_if.data_valid_o, 1);
    rx_if.data_ready_i = 1'b0;
    cke_i = 1'b1;

    consumeByte();
    checkOutput("consume_valid", rx_if.data_valid_o, 0);
    checkOutput("consume_data_kept", rx_if.data_o, 8'hA5);
    waitEdges(1);
    checkOutput("consume_rts_high", rs232_rts_o, 1);

    // Short glitch is rejected silently
    base_f = ferr_cnt; base_o = ovr_cnt; base_p = perr_cnt;
    rs232_rxd_i = 1'b0;
    waitEdges(3);
    rs232_rxd_i = 1'b1;
    waitEdges(40);
    checkOutput("glitch_valid", rx_if.data_valid_o, 0);
    checkOutput("glitch_pulses", (ferr_cnt - base_f) + (ovr_cnt - base_o) + (perr_cnt - base_p), 0);

    // Stop bit low -> single-cycle frame error, nothing loaded
    base_f = ferr_cnt;
    fork
      applyStimulus(8'h3C, 1'b0, 16);
      begin
        waitEdges(latency(16));
        checkOutput("ferr_pulse", rx_if.frame_err_o, 1);
        checkOutput("ferr_valid", rx_if.data_valid_o, 0);
        waitEdges(1);
        checkOutput("ferr_pulse_end", rx_if.frame_err_o, 0);
      end
    join
    checkOutput("ferr_count", ferr_cnt - base_f, 1);
    checkOutput("ferr_data_kept", rx_if.data_o, 8'hA5);

    // Overrun: 0x11 held, 0x22 dropped
    base_o = ovr_cnt;
    fork
      applyStimulus(8'h11, 1'b1, 16);
      begin
        waitEdges(latency(16));
        checkOutput("ovr_first_data", rx_if.data_o, 8'h11);
      end
    join
    fork
      applyStimulus(8'h22, 1'b1, 16);
      begin
        waitEdges(latency(16));
        checkOutput("ovr_pulse", rx_if.overrun_o, 1);
        checkOutput("ovr_data_kept", rx_if.data_o, 8'h11);
        checkOutput("ovr_valid", rx_if.data_valid_o, 1);
        waitEdges(1);
        checkOutput("ovr_pulse_end", rx_if.overrun_o, 0);
      end
    join
    checkOutput("ovr_count", ovr_cnt - base_o, 1);

    // Same again, but the held byte is consumed in the load cycle
    base_o = ovr_cnt;
    fork
      applyStimulus(8'h22, 1'b1, 16);
      begin
        waitEdges(latency(16) - 1);
        rx_if.data_ready_i = 1'b1;
        waitEdges(1);
        rx_if.data_ready_i = 1'b0;
        checkOutput("swap_data", rx_if.data_o, 8'h22);
        checkOutput("swap_valid", rx_if.data_valid_o, 1);
        checkOutput("swap_no_ovr", rx_if.overrun_o, 0);
      end
    join
    checkOutput("swap_ovr_count", ovr_cnt - base_o, 0);
    consumeByte();

    // Divisor 0 behaves as 2
    div_i = '0;
    fork
      applyStimulus(8'hC3, 1'b1, 2);
      begin
        waitEdges(latency(2) - 1);
        checkOutput("div2_valid_early", rx_if.data_valid_o, 0);
        waitEdges(1);
        checkOutput("div2_valid", rx_if.data_valid_o, 1);
        checkOutput("div2_data", rx_if.data_o, 8'hC3);
      end
    join
    consumeByte();
    div_i = 16'd16;

    // Receiver disabled: RTS low and frames ignored
    en_i = 1'b0;
    waitEdges(2);
    checkOutput("dis_rts", rs232_rts_o, 0);
    applyStimulus(8'h99, 1'b1, 16);
    checkOutput("dis_valid", rx_if.data_valid_o, 0);
    en_i = 1'b1;
    waitEdges(2);
    checkOutput("en_rts", rs232_rts_o, 1);

`ifdef IOB_UART_RX_PARITY_EN
    // Correct even parity accepted
    par_flip = 1'b0;
    fork
      applyStimulus(8'h07, 1'b1, 16);
      begin
        waitEdges(latency(16));
        checkOutput("par_ok_valid", rx_if.data_valid_o, 1);
        checkOutput("par_ok_data", rx_if.data_o, 8'h07);
        checkOutput("par_ok_no_err", rx_if.parity_err_o, 0);
      end
    join
    consumeByte();

    // Wrong parity bit: pulse, no load
    par_flip = 1'b1;
    base_p = perr_cnt;
    fork
      applyStimulus(8'h07, 1'b1, 16);
      begin
        waitEdges(latency(16));
        checkOutput("par_bad_pulse", rx_if.parity_err_o, 1);
        checkOutput("par_bad_valid", rx_if.data_valid_o, 0);
        waitEdges(1);
        checkOutput("par_bad_pulse_end", rx_if.parity_err_o, 0);
      end
    join
    checkOutput("par_bad_count", perr_cnt - base_p, 1);
    par_flip = 1'b0;
`endif

    // Asynchronous reset mid-frame, then a clean frame
    fork
      applyStimulus(8'h55, 1'b1, 16);
      begin
        waitEdges(60);
        arst_n_i = 1'b0;
        #1;
        checkOutput("arst_rts", rs232_rts_o, 0);
        checkOutput("arst_data", rx_if.data_o, 0);
        checkOutput("arst_valid", rx_if.data_valid_o, 0);
        checkOutput("arst_pulses", {rx_if.frame_err_o, rx_if.overrun_o, rx_if.parity_err_o}, 0);
      end
    join
    arst_n_i = 1'b1;
    waitEdges(3);
    fork
      applyStimulus(8'h0F, 1'b1, 16);
      begin
        waitEdges(latency(16));
        checkOutput("post_rst_valid", rx_if.data_valid_o, 1);
        checkOutput("post_rst_data", rx_if.data_o, 8'h0F);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
